serial_frame_tx: RTL and testbench

Parallel-to-serial frame transmitter: the transmit-side counterpart of the team's 4-bit serial-in shift register. It accepts a DATA_W-bit word over a valid/ready handshake and drives a framed serial line (start bit, data bits, stop bit) at a programmable bit period, LSB- or MSB-first. It has a one-word holding buffer so consecutive words go out back-to-back with no idle gap. It sits between the parallel datapath and the chip-level serial pin.

---
 rtl/serial_frame_tx.sv | 131 +++++++++++++
 tb/tb_serial_frame_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start bit, DATA_W data bits, stop bit,
// programmable bit period, selectable bit order, one-word holding buffer.
module serial_frame_tx #(
    parameter int DATA_W = 4,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              msb_first,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              serial_out,
    output logic              frame_active,
    output logic              done
);

    localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] buf_data;
    logic              buf_msb;
    logic              buf_full;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic              sh_msb;
    logic [IDX_W-1:0]  bit_idx;
    logic [DIV_W-1:0]  div_reg;
    logic [DIV_W-1:0]  div_cnt;
    logic              bit_end;
    logic              start_frame;

    function automatic logic end_bit(input logic [DATA_W-1:0] v, input logic msb);
        return msb ? v[DATA_W-1] : v[0];
    endfunction

    assign tx_ready = !buf_full;
    assign bit_end  = (div_cnt == '0);

    // A buffered word starts a frame from IDLE or directly off the end of a stop bit.
    assign start_frame = buf_full && ((state == IDLE) || ((state == STOP) && bit_end));

    always_comb begin
        shreg_next = sh_msb ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
            state        <= IDLE;
            buf_data     <= '0;
            buf_msb      <= 1'b0;
            buf_full     <= 1'b0;
            shreg        <= '0;
            sh_msb       <= 1'b0;
            bit_idx      <= '0;
            div_reg      <= '0;
            div_cnt      <= '0;
            serial_out   <= 1'b1;
            frame_active <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_frame) begin
                state        <= START;
                shreg        <= buf_data;
                sh_msb       <= buf_msb;
                buf_full     <= 1'b0;
                div_reg      <= clk_div;
                div_cnt      <= clk_div;
                bit_idx      <= '0;
                serial_out   <= 1'b0;
                frame_active <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        serial_out   <= 1'b1;
                        frame_active <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state      <= DATA;
                            div_cnt    <= div_reg;
                            serial_out <= end_bit(shreg, sh_msb);
                        end else begin
                            div_cnt <= div_cnt - DIV_W'(1);
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            div_cnt <= div_reg;
                            if (bit_idx == LAST_IDX) begin
                                state      <= STOP;
                                serial_out <= 1'b1;
                                // done marks the last stop cycle, which is the first when the period is one cycle.
                                done       <= (div_reg == '0);
                            end else begin
                                bit_idx    <= bit_idx + IDX_W'(1);
                                shreg      <= shreg_next;
                                serial_out <= end_bit(shreg_next, sh_msb);
                            end
                        end else begin
                            div_cnt <= div_cnt - DIV_W'(1);
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            state        <= IDLE;
                            frame_active <= 1'b0;
                        end else begin
                            div_cnt <= div_cnt - DIV_W'(1);
                            done    <= (div_cnt == DIV_W'(1));
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            // Never collides with start_frame: accepting requires the buffer to be empty.
            if (tx_valid && !buf_full) begin
                buf_data <= tx_data;
                buf_msb  <= msb_first;
                buf_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: table of single frames plus hand-written
// sequences for back-to-back, mid-frame reset and mid-frame input changes.
module tb_serial_frame_tx;

    logic       clk;
    logic       rst_n;
    logic [3:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       msb_first;
    logic [7:0] clk_div;
    logic       serial_out;
    logic       frame_active;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    serial_frame_tx #(.DATA_W(4), .DIV_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .msb_first    (msb_first),
        .clk_div      (clk_div),
        .serial_out   (serial_out),
        .frame_active (frame_active),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp_seq[0] is the start bit, exp_seq[5] the stop bit.
    typedef struct {
        string      name;
        logic       msb;
        logic [7:0] div;
        logic [3:0] data;
        logic [5:0] exp_seq;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input vec_t v);
        int per;
        int total;
        int idx;
        per   = int'(v.div) + 1;
        total = 6 * per;
        tx_data   = v.data;
        msb_first = v.msb;
        clk_div   = v.div;
        tx_valid  = 1'b1;
        tick();
        tx_valid = 1'b0;
        check({v.name, " accept_ready"}, tx_ready, 1'b0);
        check({v.name, " accept_line"}, serial_out, 1'b1);
        check({v.name, " accept_active"}, frame_active, 1'b0);
        for (int k = 1; k <= total; k++) begin
            tick();
            idx = (k - 1) / per;
            check($sformatf("%s serial c%0d", v.name, k), serial_out, v.exp_seq[idx]);
            check($sformatf("%s active c%0d", v.name, k), frame_active, 1'b1);
            check($sformatf("%s done c%0d", v.name, k), done, (k == total));
        end
        tick();
        check({v.name, " end_active"}, frame_active, 1'b0);
        check({v.name, " end_line"}, serial_out, 1'b1);
        check({v.name, " end_done"}, done, 1'b0);
        check({v.name, " end_ready"}, tx_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] b2b_seq;
        logic [5:0]  seq_a;
        logic [5:0]  seq_b;
        logic        exp_bit;

        vecs[0] = '{"lsb_b_d0", 1'b0, 8'd0, 4'b1011, 6'b110110};
        vecs[1] = '{"msb_b_d2", 1'b1, 8'd2, 4'b1011, 6'b111010};
        vecs[2] = '{"lsb_5_d1", 1'b0, 8'd1, 4'h5,    6'b101010};
        vecs[3] = '{"msb_6_d0", 1'b1, 8'd0, 4'h6,    6'b101100};
        vecs[4] = '{"lsb_0_d0", 1'b0, 8'd0, 4'h0,    6'b100000};
        vecs[5] = '{"msb_f_d3", 1'b1, 8'd3, 4'hF,    6'b111110};

        // Reset with tx_valid asserted: nothing may be captured.
        rst_n     = 1'b0;
        tx_valid  = 1'b1;
        tx_data   = 4'hF;
        msb_first = 1'b0;
        clk_div   = 8'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("rst line %0d", i), serial_out, 1'b1);
            check($sformatf("rst ready %0d", i), tx_ready, 1'b1);
            check($sformatf("rst active %0d", i), frame_active, 1'b0);
            check($sformatf("rst done %0d", i), done, 1'b0);
        end
        tx_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst active %0d", i), frame_active, 1'b0);
            check($sformatf("post_rst line %0d", i), serial_out, 1'b1);
        end

        for (int i = 0; i < 6; i++) send_frame(vecs[i]);

        // Back-to-back: 4'h5 then 4'hA, LSB-first, one cycle per bit.
        b2b_seq   = 12'b110100101010;
        clk_div   = 8'd0;
        msb_first = 1'b0;
        tx_data   = 4'h5;
        tx_valid  = 1'b1;
        tick();
        check("b2b idle_line", serial_out, 1'b1);
        tx_data = 4'hA;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 0) check("b2b ready_reassert", tx_ready, 1'b1);
            if (k == 1) begin
                check("b2b second_accepted", tx_ready, 1'b0);
                tx_valid = 1'b0;
            end
            check($sformatf("b2b serial c%0d", k), serial_out, b2b_seq[k]);
            check($sformatf("b2b active c%0d", k), frame_active, 1'b1);
            check($sformatf("b2b done c%0d", k), done, (k == 5) || (k == 11));
        end
        tick();
        check("b2b end_active", frame_active, 1'b0);
        check("b2b end_line", serial_out, 1'b1);

        // Reset during the second data bit, with a second word sitting in the buffer.
        clk_div   = 8'd3;
        msb_first = 1'b0;
        tx_data   = 4'h6;
        tx_valid  = 1'b1;
        tick();
        tx_data = 4'h9;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) begin
                check("mrst buffered", tx_ready, 1'b0);
                tx_valid = 1'b0;
            end
        end
        check("mrst data_bit1", serial_out, 1'b1);
        check("mrst active_before", frame_active, 1'b1);
        rst_n = 1'b0;
        tick();
        check("mrst line", serial_out, 1'b1);
        check("mrst ready", tx_ready, 1'b1);
        check("mrst active", frame_active, 1'b0);
        check("mrst done", done, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            check($sformatf("mrst idle_line c%0d", k), serial_out, 1'b1);
            check($sformatf("mrst idle_done c%0d", k), done, 1'b0);
            check($sformatf("mrst idle_active c%0d", k), frame_active, 1'b0);
        end

        // Mid-frame changes: clk_div 1->5 during DATA, tx_data changed while tx_ready is low.
        // Frame 1: 4'hB LSB-first, 2-cycle bits. Frame 2: 4'h3 MSB-first, 6-cycle bits.
        seq_a     = 6'b110110;
        seq_b     = 6'b111000;
        clk_div   = 8'd1;
        msb_first = 1'b0;
        tx_data   = 4'hB;
        tx_valid  = 1'b1;
        tick();
        tx_data   = 4'h3;
        msb_first = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tick();
            exp_bit = (k <= 12) ? seq_a[(k - 1) / 2] : seq_b[(k - 13) / 6];
            check($sformatf("mid serial c%0d", k), serial_out, exp_bit);
            check($sformatf("mid active c%0d", k), frame_active, 1'b1);
            check($sformatf("mid done c%0d", k), done, (k == 12) || (k == 48));
            if (k == 2) begin
                tx_data   = 4'hE;
                msb_first = 1'b0;
            end
            if (k == 5) clk_div = 8'd5;
            if (k == 11) tx_valid = 1'b0;
        end
        tick();
        check("mid end_active", frame_active, 1'b0);
        check("mid end_line", serial_out, 1'b1);
        check("mid end_ready", tx_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("mid no_extra c%0d", k), frame_active, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
